// File: rtl/window_gen.sv
// Raster-scan 6x6 sliding-window generator: five line buffers feed a shifting
// window register, flagged valid only when the whole window lies inside the image.
module window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              pix_in,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  output logic [0:5][0:5][7:0]    window,
  output logic                    win_valid,
  output logic                    frame_done
);

  localparam int DATA_W = 8;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(5);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(5);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic              accept;
  logic              resync;
  logic              col_last;
  logic              row_last;
  logic              vld_p0;
  logic              done_p0;
  logic              vld_p1;
  logic              done_p1;

  logic [DATA_W-1:0] lb [0:4][0:IMG_W-1];

  // Stage p0: position of the accepted pixel, with SOF forcing (0,0)
  always_comb begin
    accept   = pix_valid && !reset;
    resync   = pix_valid && pix_sof;
    cur_col  = resync ? '0 : col;
    cur_row  = resync ? '0 : row;
    col_last = (cur_col == COL_LAST);
    row_last = (cur_row == ROW_LAST);
    vld_p0   = accept && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
    done_p0  = accept && row_last && col_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : cur_row + ROW_W'(1);
      end else begin
        col <= cur_col + COL_W'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers hold raw image data and are deliberately never cleared;
  // validity gating keeps stale rows from ever being flagged.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][cur_col] <= pix_in;
      for (int k = 1; k < 5; k++) begin
        lb[k][cur_col] <= lb[k-1][cur_col];
      end
    end
  end

  // Stage p1: window shift register and its qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      window <= '0;
    end else if (pix_valid) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 5; c++) begin
          window[r][c] <= window[r][c+1];
        end
      end
      for (int r = 0; r < 5; r++) begin
        window[r][5] <= lb[4-r][cur_col];
      end
      window[5][5] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      done_p1 <= done_p0;
    end
  end

  assign win_valid  = vld_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on an 8x8 image: table-checked first frame,
// then stall, reset, SOF-resync and back-to-back sequences against a window model.
module tb_window_gen;

  localparam int W = 8;
  localparam int H = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           pix_in;
  logic                 pix_valid;
  logic                 pix_sof;
  logic [0:5][0:5][7:0] window;
  logic                 win_valid;
  logic                 frame_done;

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .window     (window),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   nwin  = 0;
  int   nfd   = 0;
  int   expq[$];
  logic acc_q = 1'b0;

  typedef struct {
    int         idx;
    logic       v;
    logic [7:0] w00;
    logic [7:0] w05;
    logic [7:0] w50;
    logic [7:0] w55;
    logic       fd;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each flagged window is compared in full against the expected image patch.
  always @(posedge clk) acc_q <= pix_valid && !reset;

  always @(negedge clk) begin
    if (frame_done) nfd++;
    if (frame_done && !win_valid) begin
      total++;
      bad++;
      $display("FAIL fd_without_window: frame_done=1 win_valid=0");
    end
    if (win_valid) begin
      nwin++;
      total++;
      if (!acc_q) begin
        bad++;
        $display("FAIL valid_after_gap: win_valid=1 after a non-accepted cycle");
      end
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window: w55=%0d with none expected", window[5][5]);
      end else begin
        int key;
        int r;
        int c;
        int mism;
        key  = expq.pop_front();
        r    = key / W;
        c    = key % W;
        mism = 0;
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++)
            if (window[i][j] != 8'((r - 5 + i) * W + (c - 5 + j))) mism++;
        total++;
        if (mism != 0) begin
          bad++;
          $display("FAIL window_content at (%0d,%0d): %0d wrong bytes, w00=%0d w55=%0d required w00=%0d w55=%0d",
                   r, c, mism, window[0][0], window[5][5], (r - 5) * W + (c - 5), key);
        end
        check("frame_done_pos", int'(frame_done), int'(key == W * H - 1));
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] p, input logic s);
    pix_valid = v;
    pix_in    = p;
    pix_sof   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input int r, input int c, input logic s, input int gap);
    logic [0:5][0:5][7:0] held;
    for (int g = 0; g < gap; g++) begin
      held = window;
      drive(1'b0, 8'hAA, 1'b1);
      total++;
      if (window !== held) begin
        bad++;
        $display("FAIL window_hold: w55=%0d required %0d", window[5][5], held[5][5]);
      end
    end
    drive(1'b1, 8'(r * W + c), s);
    if (r >= 5 && c >= 5) expq.push_back(r * W + c);
  endtask

  task automatic send_frame(input bit stalls);
    for (int i = 0; i < W * H; i++) begin
      int gap;
      gap = 0;
      if (stalls && ($urandom_range(0, 1) == 1)) gap = $urandom_range(1, 3);
      send_px(i / W, i % W, 1'b0, gap);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_window_zero"}, int'(window == '0), 1);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    int w0;
    int f0;

    tbl[0] = '{idx: 44, v: 1'b0, w00: 8'd0,  w05: 8'd0,  w50: 8'd0,  w55: 8'd0,  fd: 1'b0};
    tbl[1] = '{idx: 45, v: 1'b1, w00: 8'd0,  w05: 8'd5,  w50: 8'd40, w55: 8'd45, fd: 1'b0};
    tbl[2] = '{idx: 46, v: 1'b1, w00: 8'd1,  w05: 8'd6,  w50: 8'd41, w55: 8'd46, fd: 1'b0};
    tbl[3] = '{idx: 48, v: 1'b0, w00: 8'd0,  w05: 8'd0,  w50: 8'd0,  w55: 8'd0,  fd: 1'b0};
    tbl[4] = '{idx: 52, v: 1'b0, w00: 8'd0,  w05: 8'd0,  w50: 8'd0,  w55: 8'd0,  fd: 1'b0};
    tbl[5] = '{idx: 53, v: 1'b1, w00: 8'd8,  w05: 8'd13, w50: 8'd48, w55: 8'd53, fd: 1'b0};
    tbl[6] = '{idx: 62, v: 1'b1, w00: 8'd17, w05: 8'd22, w50: 8'd57, w55: 8'd62, fd: 1'b0};
    tbl[7] = '{idx: 63, v: 1'b1, w00: 8'd18, w05: 8'd23, w50: 8'd58, w55: 8'd63, fd: 1'b1};

    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = 8'h00;

    // Reset with pixels presented: they must be dropped.
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h66, 1'b1);
    check_zero("reset");
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check_zero("idle");

    // Basic frame with table checks at selected pixels.
    w0 = nwin;
    f0 = nfd;
    for (int i = 0; i < W * H; i++) begin
      send_px(i / W, i % W, 1'b0, 0);
      for (int t = 0; t < 8; t++) begin
        if (tbl[t].idx == i) begin
          check($sformatf("win_valid@%0d", i), int'(win_valid), int'(tbl[t].v));
          check($sformatf("frame_done@%0d", i), int'(frame_done), int'(tbl[t].fd));
          if (tbl[t].v) begin
            check($sformatf("w00@%0d", i), int'(window[0][0]), int'(tbl[t].w00));
            check($sformatf("w05@%0d", i), int'(window[0][5]), int'(tbl[t].w05));
            check($sformatf("w50@%0d", i), int'(window[5][0]), int'(tbl[t].w50));
            check($sformatf("w55@%0d", i), int'(window[5][5]), int'(tbl[t].w55));
          end
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    check("basic_windows", nwin - w0, 9);
    check("basic_frame_done", nfd - f0, 1);

    // Same frame with random gaps.
    w0 = nwin;
    f0 = nfd;
    send_frame(1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check("stall_windows", nwin - w0, 9);
    check("stall_frame_done", nfd - f0, 1);

    // Reset at pixel (6,3), then a clean restart.
    for (int i = 0; i < 51; i++) send_px(i / W, i % W, 1'b0, 0);
    reset = 1'b1;
    drive(1'b1, 8'd51, 1'b0);
    check_zero("midreset");
    reset = 1'b0;
    w0 = nwin;
    f0 = nfd;
    for (int i = 0; i < W * H; i++) begin
      send_px(i / W, i % W, 1'b0, 0);
      if (i == 45) begin
        check("restart_first_valid", int'(win_valid), 1);
        check("restart_first_w55", int'(window[5][5]), 45);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    check("restart_windows", nwin - w0, 9);
    check("restart_frame_done", nfd - f0, 1);

    // SOF at pixel (3,2) abandons the frame in progress.
    w0 = nwin;
    f0 = nfd;
    for (int i = 0; i < 26; i++) send_px(i / W, i % W, 1'b0, 0);
    send_px(0, 0, 1'b1, 0);
    for (int i = 1; i < W * H; i++) send_px(i / W, i % W, 1'b0, 0);
    drive(1'b0, 8'h00, 1'b0);
    check("sof_windows", nwin - w0, 9);
    check("sof_frame_done", nfd - f0, 1);

    // Two frames back to back, no SOF, no gap.
    w0 = nwin;
    f0 = nfd;
    send_frame(1'b0);
    for (int i = 0; i < W * H; i++) begin
      send_px(i / W, i % W, 1'b0, 0);
      if (i == 45) check("b2b_second_w55", int'(window[5][5]), 45);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    check("b2b_windows", nwin - w0, 18);
    check("b2b_frame_done", nfd - f0, 2);
    check("pending_windows", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
